// File: rtl/neuron_wta_out_pkg.sv
// Shared types and width helpers for the winner-take-all output stage.
package neuron_wta_out_pkg;

  // Controller states: wait for a sample, scan serially, decide, hold off.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DECIDE  = 2'd2,
    REFRACT = 2'd3
  } wta_state_e;

  // Potential width: weight width plus decay shift plus accumulation headroom.
  function automatic int potWidth(input int width, input int shift);
    return width + shift + 4;
  endfunction

  // Width of a neuron index; never narrower than one bit.
  function automatic int idxWidth(input int neurons);
    return (neurons < 2) ? 1 : $clog2(neurons);
  endfunction

endpackage

// File: rtl/neuron_wta_out_if.sv
// Sample/result bundle between the neuron layer and the WTA output stage.
// The slave side is the WTA block; the master side is whoever feeds it.
interface neuron_wta_out_if #(
  parameter int p_w       = 20,
  parameter int p_neurons = 4
);
  import neuron_wta_out_pkg::*;

  localparam int p_idx = idxWidth(p_neurons);

  logic [p_neurons*p_w-1:0] i_neuronout;
  logic                     i_valid;
  logic                     i_learn;
  logic [p_neurons*p_w-1:0] o_threshold;
  logic                     o_spike;
  logic [p_idx-1:0]         o_winner;
  logic                     o_busy;
  logic                     o_dropped;

  modport master (
    output i_neuronout, i_valid, i_learn,
    input  o_threshold, o_spike, o_winner, o_busy, o_dropped
  );

  modport slave (
    input  i_neuronout, i_valid, i_learn,
    output o_threshold, o_spike, o_winner, o_busy, o_dropped
  );

endinterface

// File: rtl/neuron_threshold_bank.sv
// Per-neuron adaptive thresholds. A firing decision pulls the winner's
// threshold a fraction of the way up towards the winning potential; a
// silent decision decays every threshold down towards a floor.
module neuron_threshold_bank
  import neuron_wta_out_pkg::*;
#(
  parameter int p_w         = 20,
  parameter int p_neurons   = 4,
  parameter int p_idx       = 2,
  parameter int p_eta_shift = 3,
  parameter int p_th_init   = 100,
  parameter int p_th_min    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_upd_fire,
  input  logic                     i_upd_decay,
  input  logic [p_idx-1:0]         i_winner,
  input  logic [p_w-1:0]           i_best,
  output logic [p_neurons*p_w-1:0] o_threshold
);

  localparam logic [p_w-1:0] TH_INIT = p_w'(p_th_init);
  localparam logic [p_w-1:0] TH_MIN  = p_w'(p_th_min);

  logic [p_w-1:0] r_th      [p_neurons];
  logic [p_w-1:0] w_thNext  [p_neurons];
  logic [p_w-1:0] w_grown   [p_neurons];
  logic [p_w-1:0] w_decayed [p_neurons];

  // Candidate values per neuron; the growth term is only used when best > th,
  // so the subtraction never wraps and the result stays at or below best.
  for (genvar g = 0; g < p_neurons; g++) begin : g_cand
    assign w_grown[g]   = r_th[g] + ((i_best - r_th[g]) >> p_eta_shift);
    assign w_decayed[g] = r_th[g] - (r_th[g] >> p_eta_shift);
    assign o_threshold[g*p_w +: p_w] = r_th[g];
  end

  // Pick the next threshold for each neuron: grow the winner, or decay all
  // thresholds that are still at or above the floor, clamping at the floor.
  always_comb begin
    for (int k = 0; k < p_neurons; k++) begin
      w_thNext[k] = r_th[k];
      if (i_upd_fire && (i_winner == p_idx'(k)) && (i_best > r_th[k])) begin
        w_thNext[k] = w_grown[k];
      end else if (i_upd_decay && (r_th[k] >= TH_MIN)) begin
        w_thNext[k] = (w_decayed[k] < TH_MIN) ? TH_MIN : w_decayed[k];
      end
    end
  end

  // Threshold registers, restored to the initial value on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < p_neurons; k++) r_th[k] <= TH_INIT;
    end else begin
      for (int k = 0; k < p_neurons; k++) r_th[k] <= w_thNext[k];
    end
  end

endmodule

// File: rtl/neuron_wta_out.sv
// Winner-take-all output stage: snapshots the layer's potentials, finds the
// first maximum with a serial scan, spikes with the winner index, adapts the
// thresholds, then holds off for a refractory window.
module neuron_wta_out
  import neuron_wta_out_pkg::*;
#(
  parameter int p_width      = 8,
  parameter int p_shift      = 8,
  parameter int p_neurons    = 4,
  parameter int p_eta_shift  = 3,
  parameter int p_refractory = 8,
  parameter int p_th_init    = 100,
  parameter int p_th_min     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  neuron_wta_out_if.slave  bus
);

  localparam int W  = potWidth(p_width, p_shift);
  localparam int IW = idxWidth(p_neurons);
  localparam int CW = $clog2(p_refractory + 1);

  wta_state_e      r_state;
  logic [W-1:0]    r_snap [p_neurons];
  logic [W-1:0]    r_best;
  logic [IW-1:0]   r_bestIdx;
  logic [IW-1:0]   r_k;
  logic [CW-1:0]   r_refCnt;
  logic            r_spike;
  logic [IW-1:0]   r_winner;
  logic            r_busy;
  logic            r_dropped;

  logic            w_updFire;
  logic            w_updDecay;

  // Learning is only acted on in the decision cycle, and the kind of update
  // depends on whether anything crossed its threshold.
  assign w_updFire  = (r_state == DECIDE) && (r_best != '0) && bus.i_learn;
  assign w_updDecay = (r_state == DECIDE) && (r_best == '0) && bus.i_learn;

  // Controller, snapshot and serial argmax; all outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      for (int k = 0; k < p_neurons; k++) r_snap[k] <= '0;
      r_best    <= '0;
      r_bestIdx <= '0;
      r_k       <= '0;
      r_refCnt  <= '0;
      r_spike   <= 1'b0;
      r_winner  <= '0;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_spike   <= 1'b0;
      r_dropped <= bus.i_valid && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            for (int k = 0; k < p_neurons; k++) r_snap[k] <= bus.i_neuronout[k*W +: W];
            r_best    <= '0;
            r_bestIdx <= '0;
            r_k       <= '0;
            r_busy    <= 1'b1;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (r_snap[r_k] > r_best) begin
            r_best    <= r_snap[r_k];
            r_bestIdx <= r_k;
          end
          if (r_k == IW'(p_neurons - 1)) begin
            r_state <= DECIDE;
          end else begin
            r_k <= r_k + IW'(1);
          end
        end
        DECIDE: begin
          if (r_best != '0) begin
            r_spike  <= 1'b1;
            r_winner <= r_bestIdx;
            r_refCnt <= CW'(p_refractory);
            r_state  <= REFRACT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        REFRACT: begin
          if (r_refCnt == CW'(1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_refCnt <= r_refCnt - CW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  neuron_threshold_bank #(
    .p_w         (W),
    .p_neurons   (p_neurons),
    .p_idx       (IW),
    .p_eta_shift (p_eta_shift),
    .p_th_init   (p_th_init),
    .p_th_min    (p_th_min)
  ) u_thBank (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_upd_fire  (w_updFire),
    .i_upd_decay (w_updDecay),
    .i_winner    (r_bestIdx),
    .i_best      (r_best),
    .o_threshold (bus.o_threshold)
  );

  assign bus.o_spike   = r_spike;
  assign bus.o_winner  = r_winner;
  assign bus.o_busy    = r_busy;
  assign bus.o_dropped = r_dropped;

endmodule

// File: tb/tb_neuron_wta_out.sv
// Bench for the WTA output stage: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a timeline model.
module tb_neuron_wta_out;
  import neuron_wta_out_pkg::*;

  localparam int N       = 4;
  localparam int W       = 20;
  localparam int ETA     = 3;
  localparam int R       = 8;
  localparam int TH_INIT = 100;
  localparam int TH_MIN  = 16;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Model state: a timeline of when the pending decision lands and when the
  // block can next accept a sample, plus the threshold values it implies.
  int edgeNum    = 0;
  bit pending    = 0;
  int decideEdge = 0;
  int freeEdge   = 0;
  int mBest      = 0;
  int mWin       = 0;
  int mTh [N];
  int expSpike   = 0;
  int expWinner  = 0;
  int expBusy    = 0;
  int expDropped = 0;

  always #5 i_clk = ~i_clk;

  neuron_wta_out_if #(.p_w(W), .p_neurons(N)) bus ();

  neuron_wta_out #(
    .p_width      (8),
    .p_shift      (8),
    .p_neurons    (N),
    .p_eta_shift  (ETA),
    .p_refractory (R),
    .p_th_init    (TH_INIT),
    .p_th_min     (TH_MIN)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int a, input int b, input int c, input int d);
    logic [N*W-1:0] v;
    v[0*W +: W] = W'(a);
    v[1*W +: W] = W'(b);
    v[2*W +: W] = W'(c);
    v[3*W +: W] = W'(d);
    return v;
  endfunction

  function automatic int thOf(input int k);
    logic [N*W-1:0] t;
    t = bus.o_threshold;
    return int'(t[k*W +: W]);
  endfunction

  function automatic void modelReset();
    pending    = 0;
    freeEdge   = 0;
    for (int k = 0; k < N; k++) mTh[k] = TH_INIT;
    expSpike   = 0;
    expWinner  = 0;
    expBusy    = 0;
    expDropped = 0;
  endfunction

  // Predict the outputs that will follow the next rising edge from the
  // inputs that edge will see.
  function automatic void modelAdvance();
    int e;
    int maxVal;
    logic [N*W-1:0] vec;
    e = edgeNum + 1;
    vec = bus.i_neuronout;
    expSpike   = 0;
    expDropped = (bus.i_valid && e < freeEdge) ? 1 : 0;
    if (pending && e == decideEdge) begin
      pending = 0;
      if (mBest > 0) begin
        expSpike  = 1;
        expWinner = mWin;
        if (bus.i_learn && mBest > mTh[mWin])
          mTh[mWin] = mTh[mWin] + (mBest - mTh[mWin]) / (1 << ETA);
      end else if (bus.i_learn) begin
        for (int k = 0; k < N; k++) begin
          if (mTh[k] >= TH_MIN) begin
            mTh[k] = mTh[k] - mTh[k] / (1 << ETA);
            if (mTh[k] < TH_MIN) mTh[k] = TH_MIN;
          end
        end
      end
    end
    if (bus.i_valid && e >= freeEdge) begin
      maxVal = 0;
      for (int k = 0; k < N; k++)
        if (int'(vec[k*W +: W]) > maxVal) maxVal = int'(vec[k*W +: W]);
      mBest = maxVal;
      mWin  = 0;
      if (maxVal > 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (int'(vec[k*W +: W]) == maxVal) mWin = k;
      end
      pending    = 1;
      decideEdge = e + N + 1;
      freeEdge   = (mBest > 0) ? decideEdge + R + 1 : decideEdge + 1;
    end
    expBusy = (e + 1 < freeEdge) ? 1 : 0;
  endfunction

  // Compare the DUT against the model in the middle of every cycle, then
  // advance the model past the coming edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) modelReset();
    checkOutput("spike",   bus.o_spike,   expSpike);
    checkOutput("winner",  bus.o_winner,  expWinner);
    checkOutput("busy",    bus.o_busy,    expBusy);
    checkOutput("dropped", bus.o_dropped, expDropped);
    for (int k = 0; k < N; k++) checkOutput($sformatf("th%0d", k), thOf(k), mTh[k]);
    if (i_rst_n) modelAdvance();
    edgeNum++;
  end

  task automatic stepCycle();
    @(posedge i_clk);
    #1;
  endtask

  // Present one sample for exactly one edge, then scramble the bus so a
  // late read of the potentials would be noticed.
  task automatic applyStimulus(input logic [N*W-1:0] vec, input logic valid, input logic learn);
    bus.i_neuronout = vec;
    bus.i_valid     = valid;
    bus.i_learn     = learn;
    stepCycle();
    bus.i_valid     = 1'b0;
    bus.i_neuronout = pack($urandom_range(1, 900), $urandom_range(1, 900),
                           $urandom_range(1, 900), $urandom_range(1, 900));
  endtask

  task automatic resetDut();
    i_rst_n         = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_learn     = 1'b0;
    bus.i_neuronout = '0;
    repeat (2) stepCycle();
    i_rst_n = 1'b1;
    stepCycle();
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.o_busy && n < 60) begin
      stepCycle();
      n++;
    end
    if (bus.o_busy) checkOutput("idle_timeout", 1, 0);
  endtask

  initial begin
    int lit [3];
    lit[0] = 88;
    lit[1] = 77;
    lit[2] = 68;

    bus.i_valid     = 1'b0;
    bus.i_learn     = 1'b0;
    bus.i_neuronout = '0;
    repeat (3) stepCycle();
    i_rst_n = 1'b1;
    stepCycle();

    // Reset state
    for (int k = 0; k < N; k++) checkOutput("rst_th", thOf(k), 100);
    checkOutput("rst_spike",   bus.o_spike,   0);
    checkOutput("rst_busy",    bus.o_busy,    0);
    checkOutput("rst_dropped", bus.o_dropped, 0);
    checkOutput("rst_winner",  bus.o_winner,  0);

    // Single winner with learning, spike latency, then again without learning
    applyStimulus(pack(0, 150, 0, 0), 1'b1, 1'b1);
    checkOutput("t2_busy", bus.o_busy, 1);
    repeat (4) stepCycle();
    checkOutput("t2_early", bus.o_spike, 0);
    stepCycle();
    checkOutput("t2_spike",  bus.o_spike,  1);
    checkOutput("t2_winner", bus.o_winner, 1);
    checkOutput("t2_th1",    thOf(1),      106);
    checkOutput("t2_th0",    thOf(0),      100);
    stepCycle();
    checkOutput("t2_one", bus.o_spike, 0);
    waitIdle();
    applyStimulus(pack(0, 150, 0, 0), 1'b1, 1'b0);
    repeat (5) stepCycle();
    checkOutput("t2b_spike", bus.o_spike, 1);
    checkOutput("t2b_th1",   thOf(1),     106);
    waitIdle();

    // Tie goes to the lowest index
    resetDut();
    applyStimulus(pack(0, 200, 200, 0), 1'b1, 1'b1);
    repeat (5) stepCycle();
    checkOutput("t3_winner", bus.o_winner, 1);
    checkOutput("t3_th1",    thOf(1),      112);
    checkOutput("t3_th2",    thOf(2),      100);
    waitIdle();

    // Silent samples decay every threshold down to the floor
    resetDut();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(pack(0, 0, 0, 0), 1'b1, 1'b1);
      repeat (5) stepCycle();
      checkOutput("t4_nospike", bus.o_spike, 0);
      if (i < 3) checkOutput("t4_decay", thOf(0), lit[i]);
    end
    for (int k = 0; k < N; k++) checkOutput("t4_floor", thOf(k), 16);
    stepCycle();

    // Samples arriving while busy are dropped; the period boundary is exact
    resetDut();
    applyStimulus(pack(10, 20, 30, 40), 1'b1, 1'b1);
    stepCycle();
    bus.i_valid = 1'b1;
    stepCycle();
    checkOutput("t5_drop_scan", bus.o_dropped, 1);
    bus.i_valid = 1'b0;
    repeat (5) stepCycle();
    bus.i_valid = 1'b1;
    stepCycle();
    checkOutput("t5_drop_ref", bus.o_dropped, 1);
    checkOutput("t5_winner",   bus.o_winner,  3);
    bus.i_valid = 1'b0;
    repeat (4) stepCycle();
    bus.i_neuronout = pack(0, 0, 0, 77);
    bus.i_valid     = 1'b1;
    stepCycle();
    checkOutput("t5_drop_edge", bus.o_dropped, 1);
    checkOutput("t5_idle",      bus.o_busy,    0);
    stepCycle();
    checkOutput("t5_accept", bus.o_dropped, 0);
    checkOutput("t5_busy",   bus.o_busy,    1);
    bus.i_valid = 1'b0;
    repeat (5) stepCycle();
    checkOutput("t5_spike2", bus.o_spike,  1);
    checkOutput("t5_win2",   bus.o_winner, 3);
    checkOutput("t5_th3",    thOf(3),      100);
    waitIdle();

    // Reset in the middle of a scan abandons the sample
    resetDut();
    applyStimulus(pack(0, 0, 300, 0), 1'b1, 1'b1);
    stepCycle();
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("t6_busy", bus.o_busy, 0);
    checkOutput("t6_th2",  thOf(2),    100);
    repeat (2) stepCycle();
    i_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      stepCycle();
      checkOutput("t6_nospike", bus.o_spike, 0);
    end
    checkOutput("t6_th2_end", thOf(2), 100);

    // Randomized traffic checked by the model
    for (int i = 0; i < 600; i++) begin
      logic [N*W-1:0] vec;
      for (int k = 0; k < N; k++) begin
        int r;
        r = int'($urandom_range(0, 7));
        if (r < 3)      vec[k*W +: W] = '0;
        else if (r < 5) vec[k*W +: W] = W'(200);
        else            vec[k*W +: W] = W'($urandom_range(1, 500));
      end
      bus.i_neuronout = vec;
      bus.i_valid     = ($urandom_range(0, 3) == 0);
      bus.i_learn     = $urandom_range(0, 1) == 1;
      stepCycle();
    end
    bus.i_valid = 1'b0;
    repeat (30) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
